inst_fetch_reader: RTL and testbench

Read-side companion to the PC flop. Takes the fetch address from the PC stage, issues a single-outstanding read on the SRAM-like instruction memory bus (req/addr_ok/data_ok), and returns the instruction word to the decode stage through a valid/ready hold buffer. Supports a flush that discards an in-flight fetch. Misaligned addresses are flagged without any bus access.

---
 rtl/inst_fetch_reader_if.sv | 36 +++
 rtl/inst_fetch_reader.sv | 118 +++++++++++
 tb/tb_inst_fetch_reader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_reader_if.sv
// Fetch-side bundle: PC-stage request, decode-stage valid/ready return, flush,
// and the SRAM-like instruction bus (req/addr_ok/data_ok).
// slave = the fetch reader itself, master = the surrounding pipeline and bus.
interface inst_fetch_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_addr_ack;
  logic [DATA_WIDTH-1:0] cpu_inst;
  logic                  cpu_inst_err;
  logic                  cpu_inst_valid;
  logic                  cpu_inst_ready;
  logic                  flush;
  logic                  busy;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_inst_ready, flush,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output cpu_addr_ack, cpu_inst, cpu_inst_err, cpu_inst_valid, busy,
    output mem_req, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, cpu_inst_ready, flush,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  cpu_addr_ack, cpu_inst, cpu_inst_err, cpu_inst_valid, busy,
    input  mem_req, mem_addr
  );
endinterface

// File: rtl/inst_fetch_reader.sv
// Single-outstanding instruction fetch: PC request -> bus read -> decode hold buffer.
// Latency: ack in IDLE, cpu_inst_valid the cycle after the data_ok capture edge (3 cycles min).
// Backpressure: HOLD keeps the word until cpu_inst_ready; no new ack until the buffer drains.
module inst_fetch_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_reader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_r, addr_n;
  logic [DATA_WIDTH-1:0] inst_r, inst_n;
  logic                  err_r, err_n;
  logic                  kill, kill_n;
  logic                  ack;

  // State register; any response pending at reset is simply forgotten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Fetch address, returned word, error flag and the pending-cancel marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r <= '0;
      inst_r <= '0;
      err_r  <= 1'b0;
      kill   <= 1'b0;
    end else begin
      addr_r <= addr_n;
      inst_r <= inst_n;
      err_r  <= err_n;
      kill   <= kill_n;
    end
  end

  // Next-state and datapath decisions. A flush that arrives before the bus has
  // taken the address cannot withdraw mem_req, so it is remembered in kill and
  // the eventual response is drained in DROP.
  always_comb begin
    state_n = state;
    addr_n  = addr_r;
    inst_n  = inst_r;
    err_n   = err_r;
    kill_n  = kill;
    ack     = 1'b0;
    case (state)
      IDLE: begin
        ack = bus.cpu_req & ~bus.flush;
        if (ack) begin
          addr_n = bus.cpu_addr;
          if (bus.cpu_addr[1:0] == 2'b00) begin
            state_n = REQ;
          end else begin
            inst_n  = '0;
            err_n   = 1'b1;
            state_n = HOLD;
          end
        end
      end
      REQ: begin
        if (bus.mem_addr_ok) begin
          if (bus.mem_data_ok) begin
            if (bus.flush || kill) begin
              state_n = IDLE;
            end else begin
              inst_n  = bus.mem_rdata;
              err_n   = 1'b0;
              state_n = HOLD;
            end
          end else if (bus.flush || kill) begin
            state_n = DROP;
          end else begin
            state_n = WAIT;
          end
        end else if (bus.flush) begin
          kill_n = 1'b1;
        end
      end
      WAIT: begin
        if (bus.mem_data_ok) begin
          if (bus.flush) begin
            state_n = IDLE;
          end else begin
            inst_n  = bus.mem_rdata;
            err_n   = 1'b0;
            state_n = HOLD;
          end
        end else if (bus.flush) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (bus.mem_data_ok) state_n = IDLE;
      end
      HOLD: begin
        if (bus.cpu_inst_ready || bus.flush) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) kill_n = 1'b0;
  end

  assign bus.cpu_addr_ack   = ack;
  assign bus.cpu_inst       = inst_r;
  assign bus.cpu_inst_err   = err_r;
  assign bus.cpu_inst_valid = (state == HOLD);
  assign bus.busy           = (state != IDLE);
  assign bus.mem_req        = (state == REQ);
  assign bus.mem_addr       = (state == REQ) ? addr_r : '0;

endmodule

// File: tb/tb_inst_fetch_reader.sv
// Bench for inst_fetch_reader: vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_inst_fetch_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_reader_if ifc ();

  inst_fetch_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        fl;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        rdy;
    logic        e_ack;
    logic        e_mreq;
    logic [31:0] e_maddr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic        e_err;
    logic        e_busy;
  } vec_t;

  vec_t vt[24];

  // Reference model: bus obligations and output buffer, not pipeline states.
  bit          m_reqo;    // request visible on bus, address not yet taken
  bit          m_owed;    // address taken, data still owed by the bus
  bit          m_cancel;  // current fetch must not reach decode
  bit          m_hold;    // output buffer occupied
  bit          m_err;
  logic [31:0] m_addr;
  logic [31:0] m_inst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] a, input logic fl,
                       input logic aok, input logic dok, input logic [31:0] rd,
                       input logic rdy);
    ifc.cpu_req        = req;
    ifc.cpu_addr       = a;
    ifc.flush          = fl;
    ifc.mem_addr_ok    = aok;
    ifc.mem_data_ok    = dok;
    ifc.mem_rdata      = rd;
    ifc.cpu_inst_ready = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic req, input logic [31:0] a, input logic fl,
                              input logic aok, input logic dok, input logic [31:0] rd,
                              input logic rdy, input logic e_ack, input logic e_mreq,
                              input logic [31:0] e_maddr, input logic e_vld,
                              input logic [31:0] e_inst, input logic e_err,
                              input logic e_busy);
    vec_t v;
    v.req = req; v.addr = a; v.fl = fl; v.aok = aok; v.dok = dok; v.rd = rd; v.rdy = rdy;
    v.e_ack = e_ack; v.e_mreq = e_mreq; v.e_maddr = e_maddr; v.e_vld = e_vld;
    v.e_inst = e_inst; v.e_err = e_err; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ack"},  ifc.cpu_addr_ack,   0);
    chk({tag, ".mreq"}, ifc.mem_req,        0);
    chk({tag, ".madr"}, ifc.mem_addr,       0);
    chk({tag, ".vld"},  ifc.cpu_inst_valid, 0);
    chk({tag, ".inst"}, ifc.cpu_inst,       0);
    chk({tag, ".err"},  ifc.cpu_inst_err,   0);
    chk({tag, ".busy"}, ifc.busy,           0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] ra;
    logic        rq, fl, aok, dok, rdy;
    logic [31:0] rd;
    bit          e_busy, e_ack;

    // req addr fl aok dok rdata rdy | ack mreq maddr vld inst err busy
    vt[0]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0,                       0, 1, 32'hBFC00000, 0, 0, 0, 1);
    vt[2]  = mk(0, 0, 0, 1, 0, 0, 0,                       0, 1, 32'hBFC00000, 0, 0, 0, 1);
    vt[3]  = mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 1);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 1);
    vt[5]  = mk(0, 0, 0, 0, 1, 32'h24080001, 0,            0, 0, 0, 0, 0, 0, 1);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 1,                       0, 0, 0, 1, 32'h24080001, 0, 1);
    vt[7]  = mk(1, 32'hBFC00002, 0, 0, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0);
    vt[8]  = mk(1, 32'h4, 0, 0, 0, 0, 0,                   0, 0, 0, 1, 0, 1, 1);
    vt[9]  = mk(1, 32'h4, 0, 0, 0, 0, 1,                   0, 0, 0, 1, 0, 1, 1);
    vt[10] = mk(1, 32'h100, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    vt[11] = mk(0, 0, 1, 0, 0, 0, 0,                       0, 1, 32'h100, 0, 0, 0, 1);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0,                       0, 1, 32'h100, 0, 0, 0, 1);
    vt[13] = mk(0, 0, 0, 1, 0, 0, 0,                       0, 1, 32'h100, 0, 0, 0, 1);
    vt[14] = mk(0, 0, 1, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 1);
    vt[15] = mk(0, 0, 0, 0, 1, 32'hDEADBEEF, 0,            0, 0, 0, 0, 0, 0, 1);
    vt[16] = mk(1, 32'h200, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(0, 0, 0, 1, 0, 0, 0,                       0, 1, 32'h200, 0, 0, 0, 1);
    vt[18] = mk(0, 0, 1, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 1);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 1);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 1);
    vt[21] = mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 1);
    vt[22] = mk(0, 0, 0, 0, 1, 32'hDEADBEEF, 0,            0, 0, 0, 0, 0, 0, 1);
    vt[23] = mk(0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #12;
    chk_all_zero("reset");
    rst = 1'b1;

    // Vector table: normal fetch, misaligned, flush in REQ, flush in WAIT.
    for (int i = 0; i < 24; i++) begin
      drive(vt[i].req, vt[i].addr, vt[i].fl, vt[i].aok, vt[i].dok, vt[i].rd, vt[i].rdy);
      #1;
      chk($sformatf("v%0d.ack", i),  ifc.cpu_addr_ack,   vt[i].e_ack);
      chk($sformatf("v%0d.mreq", i), ifc.mem_req,        vt[i].e_mreq);
      chk($sformatf("v%0d.madr", i), ifc.mem_addr,       vt[i].e_maddr);
      chk($sformatf("v%0d.vld", i),  ifc.cpu_inst_valid, vt[i].e_vld);
      chk($sformatf("v%0d.busy", i), ifc.busy,           vt[i].e_busy);
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d.inst", i), ifc.cpu_inst,     vt[i].e_inst);
        chk($sformatf("v%0d.err", i),  ifc.cpu_inst_err, vt[i].e_err);
      end
      cyc();
    end

    // Reset asserted while waiting for data; late data_ok must be ignored.
    drive(1, 32'hBFC00000, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstmid.busy_before", ifc.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rstmid");
    #3;
    rst = 1'b1;
    cyc();
    drive(0, 0, 0, 0, 1, 32'h12345678, 0);
    #1;
    chk("rstlate.vld0", ifc.cpu_inst_valid, 0);
    chk("rstlate.busy0", ifc.busy, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rstlate.vld1", ifc.cpu_inst_valid, 0);
    chk("rstlate.busy1", ifc.busy, 0);
    chk("rstlate.inst", ifc.cpu_inst, 0);
    cyc();

    // Zero-wait bus, ready tied high: one fetch every three cycles, in order.
    pc = 32'h0;
    for (int i = 0; i < 9; i++) begin
      drive(1, pc, 0, 1, 1, ~(32'(i / 3) * 32'd4), 1);
      #1;
      chk($sformatf("zw%0d.ack", i), ifc.cpu_addr_ack, (i % 3) == 0);
      chk($sformatf("zw%0d.vld", i), ifc.cpu_inst_valid, (i % 3) == 2);
      if ((i % 3) == 2) chk($sformatf("zw%0d.inst", i), ifc.cpu_inst, ~(32'(i / 3) * 32'd4));
      if ((i % 3) == 0) pc = pc + 32'd4;
      cyc();
    end

    // Backpressure: word held stable and no ack while ready is low.
    drive(1, 32'h40, 0, 1, 1, 32'hCAFEF00D, 1);
    #1;
    chk("bp.ack0", ifc.cpu_addr_ack, 1);
    cyc();
    #1;
    chk("bp.mreq", ifc.mem_req, 1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(1, (k % 2 == 1) ? 32'h80 : 32'hC0, 0, 1, 1, $urandom, 0);
      #1;
      chk($sformatf("bp%0d.vld", k),  ifc.cpu_inst_valid, 1);
      chk($sformatf("bp%0d.inst", k), ifc.cpu_inst, 32'hCAFEF00D);
      chk($sformatf("bp%0d.ack", k),  ifc.cpu_addr_ack, 0);
      cyc();
    end
    drive(1, 32'h80, 0, 0, 0, 0, 1);
    #1;
    chk("bp.rdy_vld", ifc.cpu_inst_valid, 1);
    chk("bp.rdy_ack", ifc.cpu_addr_ack, 0);
    cyc();
    #1;
    chk("bp.next_ack", ifc.cpu_addr_ack, 1);
    chk("bp.next_vld", ifc.cpu_inst_valid, 0);
    cyc();

    // Random traffic against the reference model.
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    m_reqo = 0; m_owed = 0; m_cancel = 0; m_hold = 0; m_err = 0;
    m_addr = '0; m_inst = '0;
    cyc();
    for (int n = 0; n < 1500; n++) begin
      rq  = ($urandom_range(0, 3) != 0);
      ra  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      fl  = ($urandom_range(0, 9) == 0);
      aok = ($urandom_range(0, 1) == 1);
      dok = ($urandom_range(0, 2) == 0);
      rd  = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      drive(rq, ra, fl, aok, dok, rd, rdy);
      #1;
      e_busy = m_reqo | m_owed | m_hold;
      e_ack  = !e_busy && rq && !fl;
      chk($sformatf("r%0d.ack", n),  ifc.cpu_addr_ack,   e_ack);
      chk($sformatf("r%0d.mreq", n), ifc.mem_req,        m_reqo);
      chk($sformatf("r%0d.madr", n), ifc.mem_addr,       m_reqo ? m_addr : 32'h0);
      chk($sformatf("r%0d.vld", n),  ifc.cpu_inst_valid, m_hold);
      chk($sformatf("r%0d.busy", n), ifc.busy,           e_busy);
      if (m_hold) begin
        chk($sformatf("r%0d.inst", n), ifc.cpu_inst,     m_inst);
        chk($sformatf("r%0d.err", n),  ifc.cpu_inst_err, m_err);
      end
      // Advance the model by what this clock edge will do.
      if (!e_busy) begin
        if (e_ack) begin
          if (ra[1:0] != 2'b00) begin
            m_hold = 1; m_inst = 32'h0; m_err = 1;
          end else begin
            m_reqo = 1; m_addr = ra; m_cancel = 0;
          end
        end
      end else if (m_reqo) begin
        if (fl) m_cancel = 1;
        if (aok) begin
          m_reqo = 0;
          if (dok) begin
            if (!m_cancel) begin m_hold = 1; m_inst = rd; m_err = 0; end
          end else begin
            m_owed = 1;
          end
        end
      end else if (m_owed) begin
        if (fl) m_cancel = 1;
        if (dok) begin
          m_owed = 0;
          if (!m_cancel) begin m_hold = 1; m_inst = rd; m_err = 0; end
        end
      end else begin
        if (rdy || fl) m_hold = 0;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
